// File: rtl/mem_access_stage.sv
// MEM stage: data-memory and memory-mapped I/O access for loads/stores.
// Registers the MEM/WB bundle with one-cycle latency and a stall hold.
module mem_access_stage #(
  parameter int          AW          = 8,
  parameter logic [5:0]  OP_LD       = 6'd32,
  parameter logic [5:0]  OP_ST       = 6'd33,
  parameter logic [15:0] IO_IN_ADDR  = 16'hFFFE,
  parameter logic [15:0] IO_OUT_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_ex,
  input  logic [5:0]  op_ex,
  input  logic [2:0]  rd_ex,
  input  logic [15:0] ans_ex,
  input  logic [15:0] DM_data,
  input  logic [1:0]  flag_ex,
  input  logic        stall,
  input  logic [15:0] io_in,
  output logic        valid_mem,
  output logic [5:0]  op_mem,
  output logic [2:0]  rd_mem,
  output logic [15:0] ans_mem,
  output logic [1:0]  flag_mem,
  output logic [15:0] io_out,
  output logic        addr_err
);

  localparam int DEPTH = 2 ** AW;

  logic [15:0] mem_q [DEPTH];

  logic        valid_q, valid_d;
  logic [5:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [15:0] ans_q, ans_d;
  logic [1:0]  flag_q, flag_d;
  logic [15:0] io_q, io_d;
  logic        err_q, err_d;
  logic        we;

  logic          is_ld, is_st, in_rng;
  logic          hit_in, hit_out;
  logic          ld_io, ld_mem, ld_bad;
  logic          st_io, st_mem, st_bad;
  logic [AW-1:0] widx;

  assign widx    = ans_ex[AW-1:0];
  assign in_rng  = (ans_ex >> AW) == 16'd0;
  assign is_ld   = valid_ex && (op_ex == OP_LD);
  assign is_st   = valid_ex && (op_ex == OP_ST);
  assign hit_in  = ans_ex == IO_IN_ADDR;
  assign hit_out = ans_ex == IO_OUT_ADDR;

  // I/O addresses win over the range check
  assign ld_io  = is_ld && hit_in;
  assign ld_mem = is_ld && !hit_in && in_rng;
  assign ld_bad = is_ld && !hit_in && !in_rng;
  assign st_io  = is_st && hit_out;
  assign st_mem = is_st && !hit_out && in_rng;
  assign st_bad = is_st && !hit_out && !in_rng;

  always_comb begin
    valid_d = valid_ex;
    op_d    = op_ex;
    rd_d    = rd_ex;
    flag_d  = flag_ex;
    ans_d   = ans_ex;
    io_d    = io_q;
    err_d   = 1'b0;
    we      = 1'b0;
    unique case (1'b1)
      ld_io:  ans_d = io_in;
      ld_mem: ans_d = mem_q[widx];
      ld_bad: begin
        ans_d = 16'd0;
        err_d = 1'b1;
      end
      st_io:  io_d = DM_data;
      st_mem: we = 1'b1;
      st_bad: err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= 6'd0;
      rd_q    <= 3'd0;
      ans_q   <= 16'd0;
      flag_q  <= 2'd0;
      io_q    <= 16'd0;
      err_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ans_q   <= ans_d;
      flag_q  <= flag_d;
      io_q    <= io_d;
      err_q   <= err_d;
    end
  end

  // contents survive reset; writes only on an accepting edge
  always_ff @(posedge clk) begin
    if (!reset && !stall && we) begin
      mem_q[widx] <= DM_data;
    end
  end

  assign valid_mem = valid_q;
  assign op_mem    = op_q;
  assign rd_mem    = rd_q;
  assign ans_mem   = ans_q;
  assign flag_mem  = flag_q;
  assign io_out    = io_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed plan plus random traffic
// compared against an address-keyed behavioural memory model.
module tb_mem_access_stage;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex;
  logic [5:0]  op_ex;
  logic [2:0]  rd_ex;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic [1:0]  flag_ex;
  logic        stall;
  logic [15:0] io_in;
  logic        valid_mem;
  logic [5:0]  op_mem;
  logic [2:0]  rd_mem;
  logic [15:0] ans_mem;
  logic [1:0]  flag_mem;
  logic [15:0] io_out;
  logic        addr_err;

  mem_access_stage #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .op_ex(op_ex),
    .rd_ex(rd_ex), .ans_ex(ans_ex), .DM_data(DM_data),
    .flag_ex(flag_ex), .stall(stall), .io_in(io_in),
    .valid_mem(valid_mem), .op_mem(op_mem), .rd_mem(rd_mem),
    .ans_mem(ans_mem), .flag_mem(flag_mem), .io_out(io_out),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mm [int];
  logic        e_valid;
  logic [5:0]  e_op;
  logic [2:0]  e_rd;
  logic [15:0] e_ans;
  logic [1:0]  e_flag;
  logic [15:0] e_io;
  logic        e_err;
  bit          e_known;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int a;
    bit inr;
    if (reset) begin
      e_valid = 0; e_op = 0; e_rd = 0; e_ans = 0;
      e_flag = 0; e_io = 0; e_err = 0; e_known = 1;
    end else if (!stall) begin
      a   = int'(ans_ex);
      inr = a < (1 << AW);
      e_valid = valid_ex; e_op = op_ex; e_rd = rd_ex;
      e_flag = flag_ex; e_ans = ans_ex; e_err = 0; e_known = 1;
      if (valid_ex && op_ex == 6'd32) begin
        if (a == 'hFFFE) e_ans = io_in;
        else if (inr) begin
          if (mm.exists(a)) e_ans = mm[a];
          else e_known = 0;
        end else begin
          e_ans = 0;
          e_err = 1;
        end
      end else if (valid_ex && op_ex == 6'd33) begin
        if (a == 'hFFFF) e_io = DM_data;
        else if (inr) mm[a] = DM_data;
        else e_err = 1;
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".valid"}, 16'(valid_mem), 16'(e_valid));
    check({tag, ".op"}, 16'(op_mem), 16'(e_op));
    check({tag, ".rd"}, 16'(rd_mem), 16'(e_rd));
    check({tag, ".flag"}, 16'(flag_mem), 16'(e_flag));
    check({tag, ".io"}, io_out, e_io);
    check({tag, ".err"}, 16'(addr_err), 16'(e_err));
    if (e_known) check({tag, ".ans"}, ans_mem, e_ans);
  endtask

  task automatic drv(input logic r, input logic v, input logic [5:0] op,
                     input logic [2:0] rd, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] f,
                     input logic s);
    reset = r; valid_ex = v; op_ex = op; rd_ex = rd;
    ans_ex = a; DM_data = d; flag_ex = f; stall = s;
  endtask

  initial begin
    io_in = 16'h0000;
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst0");
    drv(0, 1, 33, 0, 16'h0005, 16'h1234, 0, 0);
    cyc("st5");
    drv(1, 1, 33, 0, 16'h0005, 16'hAAAA, 0, 0);
    cyc("rst_st1");
    cyc("rst_st2");
    drv(0, 1, 32, 3'd4, 16'h0005, 0, 0, 0);
    cyc("ld5");
    check("ld5_not_aaaa", ans_mem, 16'h1234);

    drv(0, 1, 33, 1, 16'h0010, 16'hBEEF, 2'b01, 0);
    cyc("st10");
    drv(0, 1, 32, 3'd6, 16'h0010, 0, 0, 0);
    cyc("ld10");
    check("ld10_data", ans_mem, 16'hBEEF);
    check("ld10_rd", 16'(rd_mem), 16'd6);

    drv(0, 1, 33, 2, 16'hFFFF, 16'h00C3, 0, 0);
    cyc("st_io");
    check("io_out_c3", io_out, 16'h00C3);
    io_in = 16'h5A5A;
    drv(0, 1, 32, 2, 16'hFFFE, 0, 0, 0);
    cyc("ld_io");
    check("io_in_5a", ans_mem, 16'h5A5A);

    drv(0, 1, 33, 0, 16'h0000, 16'h0F0F, 0, 0);
    cyc("st0");
    drv(0, 1, 32, 1, 16'h0100, 0, 0, 0);
    cyc("ld_oor");
    check("ld_oor_err", 16'(addr_err), 16'd1);
    drv(0, 1, 33, 1, 16'h0100, 16'hDEAD, 0, 0);
    cyc("st_oor");
    drv(0, 1, 33, 1, 16'hFFFE, 16'hDEAD, 0, 0);
    cyc("st_ioin");
    drv(0, 1, 32, 1, 16'hFFFF, 0, 0, 0);
    cyc("ld_ioout");
    drv(0, 1, 32, 1, 16'h0000, 0, 0, 0);
    cyc("ld0");
    check("mem0_kept", ans_mem, 16'h0F0F);

    drv(0, 1, 1, 5, 16'h8000, 0, 2'b10, 0);
    cyc("alu");
    drv(0, 0, 33, 5, 16'h0010, 16'h1111, 0, 0);
    cyc("bubble");
    drv(0, 1, 32, 5, 16'h0010, 0, 0, 0);
    cyc("ld10b");

    drv(0, 1, 33, 0, 16'h0020, 16'h1111, 0, 0);
    cyc("st20a");
    drv(0, 1, 33, 0, 16'h0022, 16'h2468, 0, 0);
    cyc("st22a");
    drv(0, 1, 33, 0, 16'h0022, 16'h2222, 0, 1);
    cyc("stall22");
    drv(0, 1, 32, 0, 16'h0022, 0, 0, 0);
    cyc("ld22");
    check("mem22_kept", ans_mem, 16'h2468);
    drv(0, 1, 33, 3, 16'h0020, 16'h7777, 1, 1);
    for (int i = 0; i < 3; i++) cyc("stall20");
    stall = 0;
    cyc("st20b");
    drv(0, 1, 32, 3, 16'h0020, 0, 0, 0);
    cyc("ld20");
    check("mem20_7777", ans_mem, 16'h7777);

    for (int i = 0; i < 16; i++) begin
      drv(0, 1, 33, 0, 16'(i), 16'($urandom), 0, 0);
      cyc("fill");
    end
    for (int i = 0; i < 400; i++) begin
      int ak, ok;
      logic [15:0] a;
      logic [5:0]  op;
      ak = $urandom_range(0, 9);
      ok = $urandom_range(0, 3);
      if (ak <= 5) a = 16'($urandom_range(0, 15));
      else if (ak == 6) a = 16'hFFFE;
      else if (ak == 7) a = 16'hFFFF;
      else if (ak == 8) a = 16'h0100 + 16'($urandom_range(0, 255));
      else a = 16'($urandom);
      if (ok == 0 || ok == 3) op = 6'd32;
      else if (ok == 1) op = 6'd33;
      else op = 6'($urandom_range(0, 31));
      io_in = 16'($urandom);
      drv($urandom_range(0, 99) < 3, $urandom_range(0, 9) != 0, op,
          3'($urandom), a, 16'($urandom), 2'($urandom),
          $urandom_range(0, 4) == 0);
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of execution_block. It consumes the ALU result (ans_ex), store data (DM_data) and flags (flag_ex), and performs the data-memory access for load and store instructions.
- It owns the on-chip data memory and two memory-mapped I/O words.
- It registers everything into the MEM/WB boundary with single-cycle latency and a stall hold.

Parameters:
- AW, 8, data-memory address width; depth = 2**AW 16-bit words.
- OP_LD, 6'd32, opcode value for a word load.
- OP_ST, 6'd33, opcode value for a word store.
- IO_IN_ADDR, 16'hFFFE, load address that returns io_in.
- IO_OUT_ADDR, 16'hFFFF, store address that writes io_out.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_ex  input  1  the EX-stage instruction is real; 0 marks a bubble.
- op_ex  input  6  opcode aligned with ans_ex.
- rd_ex  input  3  destination register index, passed through.
- ans_ex  input  16  ALU result; it is the effective address for OP_LD and OP_ST.
- DM_data  input  16  store data from execution_block.
- flag_ex  input  2  execution flags, passed through.
- stall  input  1  hold request from hazard control.
- io_in  input  16  external input word.
- valid_mem  output  1  registered valid.
- op_mem  output  6  registered opcode.
- rd_mem  output  3  registered destination index.
- ans_mem  output  16  registered result (load data or ALU result).
- flag_mem  output  2  registered flags.
- io_out  output  16  memory-mapped output register.
- addr_err  output  1  the instruction just accepted addressed a non-existent location.

Behaviour:
- Reset: at a rising edge with reset=1, valid_mem, op_mem, rd_mem, ans_mem, flag_mem, io_out and addr_err are all set to 0.
  - Reset has priority over stall.
  - No memory write occurs in a reset cycle, even if OP_ST is presented.
  - Memory contents are not cleared; a location reads undefined until it is written.
- Stall: with stall=1 and reset=0, every output and the memory hold their values. No write and no io_out update occur.
- Accept: with reset=0 and stall=0, each edge captures the EX inputs. Latency is exactly 1 cycle for every op.
  - Pass-through fields: valid_mem<=valid_ex, op_mem<=op_ex, rd_mem<=rd_ex, flag_mem<=flag_ex.
- In range: an address is in range when ans_ex[15:AW]==0.
- Load (valid_ex=1, op_ex=OP_LD):
  - ans_ex==IO_IN_ADDR: ans_mem<=io_in, sampled at this edge.
  - Else, in range: ans_mem<=mem[ans_ex[AW-1:0]].
  - Else: ans_mem<=0 and addr_err<=1.
- Store (valid_ex=1, op_ex=OP_ST):
  - ans_ex==IO_OUT_ADDR: io_out<=DM_data.
  - Else, in range: mem[ans_ex[AW-1:0]]<=DM_data.
  - Else: no write and addr_err<=1.
  - In all store cases ans_mem<=ans_ex.
- Other ops, or valid_ex=0: ans_mem<=ans_ex, with no memory or I/O side effect. A bubble never writes, even if op_ex=OP_ST.
- addr_err: set to 0 on every accepted edge except the error cases above, so it is a one-accepted-instruction pulse. It is held during stall.
- I/O priority: IO_IN_ADDR and IO_OUT_ADDR are decoded before the range check. A store to IO_IN_ADDR is out of range when AW<16 and sets addr_err. A load from IO_OUT_ADDR likewise returns 0 with addr_err=1.
- Store-then-load to the same address on consecutive accepted cycles: the load returns the newly stored value. The write completes at the first edge, so no bypass logic is needed.
- Stall landing on a store: the write happens only on the edge where the store is accepted (stall=0), exactly once. It is never repeated while a later stall holds the stage.

Test Plan:
- reset=1 for 2 edges, then 0 -> all outputs 0. Store presented during reset (addr 16'h0005, data 16'hAAAA); a later load of 16'h0005 must not return 16'hAAAA, given a prior write of 16'h1234 there.
- Store 16'hBEEF to 16'h0010, then load 16'h0010 on the next cycle -> ans_mem=16'hBEEF one cycle after the load, valid_mem=1, rd_mem equals the load's rd_ex.
- Store 16'h00C3 to 16'hFFFF -> io_out=16'h00C3 after one edge. Then io_in=16'h5A5A with a load from 16'hFFFE -> ans_mem=16'h5A5A.
- Load 16'h0100 with AW=8 -> ans_mem=0 and addr_err=1 for one cycle. A store to 16'h0100 -> addr_err=1, and mem[0] is unchanged (verify by loading 16'h0000).
- ALU op 6'd1 with ans_ex=16'h8000, flag_ex=2'b10 -> ans_mem=16'h8000, flag_mem=2'b10 next cycle. A bubble with op_ex=OP_ST -> no write, valid_mem=0.
- Store 16'h7777 to 16'h0020 with stall=1 for 3 cycles -> outputs frozen and mem[0x20] unchanged. Release stall -> write occurs once, and a subsequent load returns 16'h7777.
